j_wgt_shift_seq: RTL and testbench

Sequencer that drives one weight shifter through a list of filters stored back-to-back in weight SRAM. It converts a per-layer configuration (base address, words per filter, filter count, pass count) into one shift_start/end_addr/img_size launch per filter, and waits for the shifter to return to idle between launches. It sits between the layer controller and the weight shifter. It also gates launches on downstream PE readiness and supports graceful abort.

---
 rtl/j_wgt_shift_seq_if.sv | 37 +++
 rtl/j_wgt_shift_seq.sv | 191 +++++++++++++++++++
 tb/tb_j_wgt_shift_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/j_wgt_shift_seq_if.sv
// rtl/j_wgt_shift_seq_if.sv - config, abort/ready and shifter handshake bundle for the weight shift sequencer
interface j_wgt_shift_seq_if #(
  parameter int ADDR_W = 18,
  parameter int FILT_W = 10,
  parameter int PASS_W = 4
);
  logic              cfg_start;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [ADDR_W-1:0] cfg_filt_len;
  logic [FILT_W-1:0] cfg_num_filt;
  logic [PASS_W-1:0] cfg_num_pass;
  logic              abort;
  logic              pe_ready;
  logic              shift_idle;
  logic              shift_start;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] img_size;
  logic [FILT_W-1:0] filt_idx;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              err;

  // Sequencer side
  modport master (
    input  cfg_start, cfg_base_addr, cfg_filt_len, cfg_num_filt, cfg_num_pass,
    input  abort, pe_ready, shift_idle,
    output shift_start, end_addr, img_size, filt_idx, busy, done, aborted, err
  );

  // Layer controller / shifter side
  modport slave (
    output cfg_start, cfg_base_addr, cfg_filt_len, cfg_num_filt, cfg_num_pass,
    output abort, pe_ready, shift_idle,
    input  shift_start, end_addr, img_size, filt_idx, busy, done, aborted, err
  );
endinterface

// File: rtl/j_wgt_shift_seq.sv
// rtl/j_wgt_shift_seq.sv - walks a weight shifter through back-to-back filters over several passes
module j_wgt_shift_seq #(
  parameter int SRAM_DEPTH  = 262144,
  parameter int SRAM_ADDR_W = $clog2(SRAM_DEPTH),
  parameter int FILT_W      = 10,
  parameter int PASS_W      = 4,
  parameter int BUSY_TMO    = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  j_wgt_shift_seq_if.master   bus
);

  localparam int TMO_W = (BUSY_TMO < 2) ? 1 : $clog2(BUSY_TMO);
  localparam logic [TMO_W-1:0]       TMO_LAST = TMO_W'(BUSY_TMO - 1);
  localparam logic [SRAM_ADDR_W-1:0] ADDR_ONE = SRAM_ADDR_W'(1);
  localparam logic [FILT_W-1:0]      FILT_ONE = FILT_W'(1);
  localparam logic [PASS_W-1:0]      PASS_ONE = PASS_W'(1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE, NEXT, FIN
  } state_t;

  state_t                 state_q, state_d;
  logic [SRAM_ADDR_W-1:0] base_q, base_d;
  logic [SRAM_ADDR_W-1:0] len_q, len_d;
  logic [FILT_W-1:0]      num_filt_q, num_filt_d;
  logic [PASS_W-1:0]      num_pass_q, num_pass_d;
  logic [SRAM_ADDR_W-1:0] end_addr_q, end_addr_d;
  logic [SRAM_ADDR_W-1:0] img_size_q, img_size_d;
  logic [FILT_W-1:0]      filt_idx_q, filt_idx_d;
  logic [PASS_W-1:0]      pass_cnt_q, pass_cnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   abort_q, abort_d;
  logic                   aborted_q, aborted_d;
  logic                   busy_q, busy_d;
  logic                   shift_start_q, shift_start_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   cfg_ok;

  assign cfg_ok = (bus.cfg_filt_len != '0) && (bus.cfg_num_filt != '0) &&
                  (bus.cfg_num_pass != '0);

  // Next-state and next-output logic; every output is registered
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    len_d         = len_q;
    num_filt_d    = num_filt_q;
    num_pass_d    = num_pass_q;
    end_addr_d    = end_addr_q;
    img_size_d    = img_size_q;
    filt_idx_d    = filt_idx_q;
    pass_cnt_d    = pass_cnt_q;
    tmo_d         = tmo_q;
    aborted_d     = aborted_q;
    busy_d        = busy_q;
    shift_start_d = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    // abort is sticky for the whole job so the filter in flight is allowed to finish
    abort_d       = abort_q | (busy_q & bus.abort);

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (bus.cfg_start) begin
          if (!cfg_ok) begin
            err_d = 1'b1;
          end else begin
            base_d     = bus.cfg_base_addr;
            len_d      = bus.cfg_filt_len;
            num_filt_d = bus.cfg_num_filt;
            num_pass_d = bus.cfg_num_pass;
            end_addr_d = bus.cfg_base_addr + bus.cfg_filt_len - ADDR_ONE;
            img_size_d = bus.cfg_filt_len - ADDR_ONE;
            filt_idx_d = '0;
            pass_cnt_d = '0;
            busy_d     = 1'b1;
            aborted_d  = 1'b0;
            state_d    = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        if (abort_d) begin
          state_d = FIN;
        end else if (bus.shift_idle && bus.pe_ready) begin
          shift_start_d = 1'b1;
          tmo_d         = '0;
          state_d       = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!bus.shift_idle) begin
          state_d = WAIT_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          abort_d = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (bus.shift_idle) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (abort_d) begin
          state_d = FIN;
        end else if (filt_idx_q == num_filt_q - FILT_ONE) begin
          if (pass_cnt_q == num_pass_q - PASS_ONE) begin
            state_d = FIN;
          end else begin
            pass_cnt_d = pass_cnt_q + PASS_ONE;
            filt_idx_d = '0;
            end_addr_d = base_q + len_q - ADDR_ONE;
            state_d    = LAUNCH;
          end
        end else begin
          filt_idx_d = filt_idx_q + FILT_ONE;
          end_addr_d = end_addr_q + len_q;
          state_d    = LAUNCH;
        end
      end
      FIN: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        aborted_d = abort_q;
        abort_d   = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      num_filt_q    <= '0;
      num_pass_q    <= '0;
      end_addr_q    <= '0;
      img_size_q    <= '0;
      filt_idx_q    <= '0;
      pass_cnt_q    <= '0;
      tmo_q         <= '0;
      abort_q       <= 1'b0;
      aborted_q     <= 1'b0;
      busy_q        <= 1'b0;
      shift_start_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      len_q         <= len_d;
      num_filt_q    <= num_filt_d;
      num_pass_q    <= num_pass_d;
      end_addr_q    <= end_addr_d;
      img_size_q    <= img_size_d;
      filt_idx_q    <= filt_idx_d;
      pass_cnt_q    <= pass_cnt_d;
      tmo_q         <= tmo_d;
      abort_q       <= abort_d;
      aborted_q     <= aborted_d;
      busy_q        <= busy_d;
      shift_start_q <= shift_start_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign bus.shift_start = shift_start_q;
  assign bus.end_addr    = end_addr_q;
  assign bus.img_size    = img_size_q;
  assign bus.filt_idx    = filt_idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_j_wgt_shift_seq.sv
// tb/tb_j_wgt_shift_seq.sv - randomized and directed bench for the weight shift sequencer
module tb_j_wgt_shift_seq;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  j_wgt_shift_seq_if #(.ADDR_W(AW), .FILT_W(10), .PASS_W(4)) bus ();

  j_wgt_shift_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int sh_mode = 0;
  int sh_lat = 20;
  int sh_cnt = 0;
  int n_done, n_err, n_dbl;
  bit done_aborted, done_busy, prev_start;
  int start_cyc, err_cyc;
  logic [AW-1:0] got_end[$];
  logic [AW-1:0] got_img[$];
  logic [9:0]    got_idx[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Shifter model plus monitor, evaluated away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      bus.shift_idle = 1'b1;
      sh_cnt = 0;
      prev_start = 1'b0;
    end else begin
      if (bus.shift_start) begin
        got_end.push_back(bus.end_addr);
        got_img.push_back(bus.img_size);
        got_idx.push_back(bus.filt_idx);
        start_cyc = cyc;
        if (prev_start) n_dbl++;
        if (sh_mode == 0) begin
          bus.shift_idle = 1'b0;
          sh_cnt = sh_lat;
        end
      end else if (sh_cnt > 0) begin
        sh_cnt--;
        if (sh_cnt == 0) bus.shift_idle = 1'b1;
      end
      prev_start = bus.shift_start;
      if (bus.done) begin
        n_done++;
        done_aborted = bus.aborted;
        done_busy = bus.busy;
      end
      if (bus.err) begin
        n_err++;
        err_cyc = cyc;
      end
    end
  end

  task automatic clear_mon();
    got_end.delete();
    got_img.delete();
    got_idx.delete();
    n_done = 0;
    n_err = 0;
    n_dbl = 0;
    done_aborted = 1'b0;
    done_busy = 1'b0;
  endtask

  task automatic start_cfg(input logic [AW-1:0] base, input logic [AW-1:0] len,
                           input logic [9:0] nf, input logic [3:0] np);
    @(negedge clk); #1;
    bus.cfg_base_addr = base;
    bus.cfg_filt_len  = len;
    bus.cfg_num_filt  = nf;
    bus.cfg_num_pass  = np;
    bus.cfg_start     = 1'b1;
    @(negedge clk); #1;
    bus.cfg_start     = 1'b0;
  endtask

  task automatic wait_end(input int max, input bit rand_pe, input string tag);
    int k = 0;
    while ((n_done + n_err) == 0 && k < max) begin
      if (rand_pe) bus.pe_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk); #1;
      k++;
    end
    bus.pe_ready = 1'b1;
    check_eq({tag, "_ended"}, ((n_done + n_err) > 0), 1);
  endtask

  task automatic wait_launches(input int n);
    int k = 0;
    while (got_end.size() < n && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
  endtask

  // Reference: filter f of any pass ends at base + (f+1)*len - 1 in an AW-bit space
  task automatic finish_run(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] len,
                            input int nf, input int np, input int nexp, input bit exp_abort);
    int i = 0;
    logic [AW-1:0] e;
    check_eq({tag, "_n_launch"}, got_end.size(), nexp);
    for (int p = 0; p < np; p++) begin
      for (int f = 0; f < nf; f++) begin
        if (i < nexp && i < got_end.size()) begin
          e = AW'(int'(base) + (f + 1) * int'(len) - 1);
          check_eq($sformatf("%s_end%0d", tag, i), got_end[i], e);
          check_eq($sformatf("%s_img%0d", tag, i), got_img[i], len - 1);
          check_eq($sformatf("%s_idx%0d", tag, i), got_idx[i], f);
        end
        i++;
      end
    end
    check_eq({tag, "_n_done"}, n_done, 1);
    check_eq({tag, "_n_err"}, n_err, 0);
    check_eq({tag, "_aborted"}, done_aborted, exp_abort);
    check_eq({tag, "_busy_at_done"}, done_busy, 0);
    check_eq({tag, "_dbl_pulse"}, n_dbl, 0);
  endtask

  initial begin
    logic [AW-1:0] rb, rl;
    int rnf, rnp, k;

    bus.cfg_start = 1'b0;
    bus.cfg_base_addr = '0;
    bus.cfg_filt_len = '0;
    bus.cfg_num_filt = '0;
    bus.cfg_num_pass = '0;
    bus.abort = 1'b0;
    bus.pe_ready = 1'b1;
    bus.shift_idle = 1'b1;
    clear_mon();

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_shift_start", bus.shift_start, 0);
    check_eq("rst_end_addr", bus.end_addr, 0);
    check_eq("rst_img_size", bus.img_size, 0);
    check_eq("rst_filt_idx", bus.filt_idx, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_aborted", bus.aborted, 0);
    check_eq("rst_err", bus.err, 0);
    reset_n = 1'b1;

    // Three filters, one pass, with a stray start while busy
    clear_mon();
    sh_lat = 20;
    start_cfg(18'h100, 16, 3, 1);
    check_eq("t1_busy_after_start", bus.busy, 1);
    wait_launches(1);
    bus.cfg_base_addr = 18'h3000;
    bus.cfg_num_filt = 1;
    bus.cfg_start = 1'b1;
    @(negedge clk); #1;
    bus.cfg_start = 1'b0;
    check_eq("t1_busy_ignore_start", bus.busy, 1);
    wait_end(2000, 1'b0, "t1");
    finish_run("t1", 18'h100, 16, 3, 1, 3, 1'b0);

    // Two passes over two filters
    clear_mon();
    sh_lat = 6;
    start_cfg(0, 4, 2, 2);
    wait_end(2000, 1'b0, "t2");
    finish_run("t2", 0, 4, 2, 2, 4, 1'b0);

    // Address wrap at the top of SRAM
    clear_mon();
    start_cfg(18'h3FFF8, 16, 2, 1);
    wait_end(2000, 1'b0, "t3");
    finish_run("t3", 18'h3FFF8, 16, 2, 1, 2, 1'b0);

    // Launch gated on PE readiness
    clear_mon();
    bus.pe_ready = 1'b0;
    start_cfg(18'h40, 8, 1, 1);
    repeat (10) @(negedge clk);
    #1;
    check_eq("t4_no_launch_while_not_ready", got_end.size(), 0);
    bus.pe_ready = 1'b1;
    wait_end(2000, 1'b0, "t4");
    finish_run("t4", 18'h40, 8, 1, 1, 1, 1'b0);

    // Abort during filter 1 of 4
    clear_mon();
    sh_lat = 20;
    start_cfg(0, 4, 4, 1);
    wait_launches(2);
    repeat (5) @(negedge clk);
    #1;
    bus.abort = 1'b1;
    @(negedge clk); #1;
    bus.abort = 1'b0;
    wait_end(2000, 1'b0, "t5");
    finish_run("t5", 0, 4, 4, 1, 2, 1'b1);
    check_eq("t5_aborted_held", bus.aborted, 1);

    // Abort while waiting in LAUNCH before any pulse
    clear_mon();
    bus.pe_ready = 1'b0;
    start_cfg(0, 4, 4, 1);
    check_eq("t5b_aborted_cleared", bus.aborted, 0);
    repeat (3) @(negedge clk);
    #1;
    bus.abort = 1'b1;
    @(negedge clk); #1;
    bus.abort = 1'b0;
    wait_end(200, 1'b0, "t5b");
    finish_run("t5b", 0, 4, 4, 1, 0, 1'b1);

    // Zero in each config field
    for (int z = 0; z < 3; z++) begin
      clear_mon();
      start_cfg(18'h10, (z == 0) ? 18'd0 : 18'd4, (z == 1) ? 10'd0 : 10'd2,
                (z == 2) ? 4'd0 : 4'd1);
      check_eq($sformatf("t6_bad%0d_err", z), bus.err, 1);
      check_eq($sformatf("t6_bad%0d_busy", z), bus.busy, 0);
      repeat (5) @(negedge clk);
      #1;
      check_eq($sformatf("t6_bad%0d_n_err", z), n_err, 1);
      check_eq($sformatf("t6_bad%0d_launch", z), got_end.size() + n_done, 0);
    end

    // Shifter that never leaves idle
    clear_mon();
    sh_mode = 1;
    start_cfg(18'h10, 2, 2, 1);
    wait_end(200, 1'b0, "t6_tmo");
    check_eq("t6_tmo_n_err", n_err, 1);
    check_eq("t6_tmo_n_done", n_done, 0);
    check_eq("t6_tmo_latency", err_cyc - start_cyc, 3);
    check_eq("t6_tmo_n_launch", got_end.size(), 1);
    check_eq("t6_tmo_busy", bus.busy, 0);
    sh_mode = 0;
    repeat (3) @(negedge clk);

    // Randomized jobs with random PE readiness
    for (int r = 0; r < 8; r++) begin
      clear_mon();
      rb = AW'($urandom);
      rl = AW'($urandom_range(1, 40));
      rnf = $urandom_range(1, 4);
      rnp = $urandom_range(1, 3);
      sh_lat = $urandom_range(1, 6);
      start_cfg(rb, rl, 10'(rnf), 4'(rnp));
      wait_end(5000, 1'b1, $sformatf("rnd%0d", r));
      finish_run($sformatf("rnd%0d", r), rb, rl, rnf, rnp, rnf * rnp, 1'b0);
    end

    // Reset on the cycle a launch pulse is out
    clear_mon();
    sh_lat = 30;
    start_cfg(0, 8, 3, 1);
    k = 0;
    while (!bus.shift_start && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    check_eq("t7_saw_pulse", bus.shift_start, 1);
    reset_n = 1'b0;
    #1;
    check_eq("t7_rst_shift_start", bus.shift_start, 0);
    check_eq("t7_rst_busy", bus.busy, 0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    clear_mon();
    sh_lat = 4;
    start_cfg(18'h200, 3, 2, 1);
    wait_end(2000, 1'b0, "t7_after");
    finish_run("t7_after", 18'h200, 3, 2, 1, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
